excp_irq_ctrl: RTL
==================

Name: excp_irq_ctrl

Overview:
- N-channel machine-level interrupt controller for the exception unit.
- Supersedes the fixed three-source interrupt request logic with parametrised per-channel state:
  - pending latching, with level or edge mode per channel;
  - enable masking;
  - fixed-priority arbitration;
  - registered cause;
  - ack/complete handshake.
- Outputs feed the PC unit (interrupt take) and the WFI logic in the exception top.

Parameters:
- NUM_IRQ, 8, number of interrupt channels (2..32).
- XLEN, 32, width of the cause word.
- CAUSE_BASE, 16, cause code of channel 0; channel i reports CAUSE_BASE+i.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dbg_mode  in  1  debug mode; masks all requests and the WFI wake.
- irq_in  in  NUM_IRQ  raw interrupt lines.
- irq_en  in  NUM_IRQ  per-channel enable from CSR.
- irq_edge  in  NUM_IRQ  per channel: 1 = rising-edge mode, 0 = level mode.
- status_mie_r  in  1  global MIE from mstatus.
- irq_i_wfi_flag_r  in  1  core is sleeping in WFI.
- irq_i_ack  in  1  single-cycle pulse: PC unit has taken the presented interrupt.
- irq_i_cmpl  in  1  single-cycle pulse: handler done (mret).
- irq_o_irq_req  out  1  interrupt must be taken.
- irq_o_irq_cause  out  XLEN  mcause value.
- irq_o_wfi_irq_req  out  1  WFI wake request.
- irq_o_irq_req_active  out  1  irq_o_wfi_irq_req when irq_i_wfi_flag_r=1, else irq_o_irq_req.
- irq_o_pend  out  NUM_IRQ  pending vector.
- irq_o_in_service  out  NUM_IRQ  one-hot channel being serviced, 0 if none.

Behaviour:
- Reset values: all outputs 0, pend 0, previous-input register 0, state IDLE.

Pending logic:
- Level channel: pend[i] follows irq_in[i], registered.
- Edge channel:
  - pend[i] sets on irq_in[i] & ~prev[i];
  - pend[i] clears on ack when i is the selected channel;
  - set wins over clear when both occur in the same cycle.

Arbitration and gating:
- eligible = pend & irq_en & ~in_service.
- Selected channel = lowest-index set bit of eligible.
- mie_w2 = status_mie_r | status_mie_r delayed by one clk. This stretches MIE across the pipe-flush cycle.
- Request condition = ~dbg_mode & mie_w2 & (eligible != 0) & (state is not ISR).

State machine, with states IDLE, REQ, ISR:
- IDLE -> REQ when the request condition holds.
  - irq_o_irq_req is registered high.
  - irq_o_irq_cause is registered: bit XLEN-1 = 1, low bits = CAUSE_BASE + selected index, all other bits 0.
- REQ, cause handling: the cause is frozen. A higher-priority arrival does not change it.
- REQ -> ISR on irq_i_ack.
  - irq_o_in_service = one-hot of the frozen channel.
  - irq_o_irq_req drops the next cycle.
- REQ -> IDLE if the frozen channel is no longer eligible, or if dbg_mode=1, or if mie_w2=0.
  - irq_o_irq_req drops and cause returns to 0.
  - If irq_i_ack occurs in the same cycle, ack wins.
- ISR -> IDLE on irq_i_cmpl; in_service clears.
- No nesting: while in ISR, irq_o_irq_req stays 0.
- irq_i_ack outside REQ and irq_i_cmpl outside ISR are ignored.

Latency:
- irq_in to pend: 1 clk.
- pend to irq_o_irq_req: 1 clk.
- Total: 2 clk from input assertion to request.

WFI:
- irq_o_wfi_irq_req = ~dbg_mode & |(pend & irq_en). This is combinational from registers, ignores MIE, and ignores state.

Reset mid-operation: everything returns to IDLE immediately and asynchronously; pending edges are lost.

Optional Feature:
- Macro: EXCP_IRQ_EDGE_EN.
- Defined: edge mode is supported per irq_edge, as described above.
- Undefined:
  - irq_edge is ignored and every channel is level-sensitive;
  - the prev register and the edge-clear logic are not built.

Decomposition:
- Shared constants go in mcu_defines.v:
  - XLEN;
  - state encodings IRQ_ST_IDLE=2'd0, IRQ_ST_REQ=2'd1, IRQ_ST_ISR=2'd2;
  - the default CAUSE_BASE.
- One sub-module, excp_irq_prio_enc, parametrised by NUM_IRQ.
  - Inputs: the eligible vector.
  - Outputs: valid, binary index, one-hot grant.

Test Plan:
- Level request with no ack:
  - Stimulus: NUM_IRQ=8, MIE=1, irq_en=8'hFF; irq_in[3] level high at cycle 0.
  - Response: irq_o_irq_req=1 at cycle 2; cause=32'h8000_0013.
- Ack and complete:
  - Stimulus: pulse irq_i_ack.
  - Response: in_service=8'h08 and req=0 the next cycle, held until irq_i_cmpl; then, with irq_in[3] still high, req reasserts.
- Simultaneous arrivals with a late higher-priority one:
  - Stimulus: irq_in[5] and irq_in[2] high in the same cycle.
  - Response: cause low bits = 18.
  - Stimulus: irq_in[0] rises during REQ.
  - Response: cause stays 18 until ack; after cmpl, cause = 16.
- MIE stretch and dbg_mode:
  - Stimulus: drop MIE for one cycle.
  - Response: req is held.
  - Stimulus: MIE low for 2 cycles.
  - Response: REQ -> IDLE.
  - Stimulus: dbg_mode=1 with pend set.
  - Response: req=0 and wfi_irq_req=0.
- WFI wake:
  - Stimulus: MIE=0, wfi_flag=1, irq_in[1] high.
  - Response: irq_o_irq_req_active=1 and irq_o_irq_req=0.
- Edge mode (EXCP_IRQ_EDGE_EN defined):
  - Stimulus: 1-cycle pulse on irq_in[4] with edge mode set.
  - Response: pend[4] stays set after the pulse ends and clears on ack.
  - Stimulus: rst_n low while in REQ.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/excp_irq_ctrl_pkg.sv
// Shared constants and FSM state type for the machine-level interrupt controller.
package excp_irq_ctrl_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_CAUSE_BASE = 16;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE = 2'd0,
        IRQ_ST_REQ  = 2'd1,
        IRQ_ST_ISR  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/excp_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest-index set bit of the eligible vector wins.
module excp_irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]         eligible,
    output logic                       valid,
    output logic [$clog2(NUM_IRQ)-1:0] index,
    output logic [NUM_IRQ-1:0]         grant
);

    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    always_comb begin
        valid = |eligible;
        index = '0;
        grant = '0;
        // Scan from the top so the lowest set bit is the last (winning) write.
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (eligible[i-1]) begin
                index      = IDX_W'(i - 1);
                grant      = '0;
                grant[i-1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/excp_irq_ctrl.sv
// N-channel interrupt controller: pending latch, enable mask, fixed priority, ack/complete handshake.
// Optional macro EXCP_IRQ_EDGE_EN enables per-channel rising-edge mode via irq_edge.
module excp_irq_ctrl
    import excp_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 8,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned CAUSE_BASE = DEF_CAUSE_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dbg_mode,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic               status_mie_r,
    input  logic               irq_i_wfi_flag_r,
    input  logic               irq_i_ack,
    input  logic               irq_i_cmpl,
    output logic               irq_o_irq_req,
    output logic [XLEN-1:0]    irq_o_irq_cause,
    output logic               irq_o_wfi_irq_req,
    output logic               irq_o_irq_req_active,
    output logic [NUM_IRQ-1:0] irq_o_pend,
    output logic [NUM_IRQ-1:0] irq_o_in_service
);

    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] frozen_q, frozen_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic               req_q, req_d;
    logic [XLEN-1:0]    cause_q, cause_d;
    logic               mie_d_q;

    logic [NUM_IRQ-1:0] eligible;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_index;
    logic [NUM_IRQ-1:0] sel_grant;
    logic               mie_w2;
    logic               ack_take;
    logic               req_cond;

    assign eligible = pend_q & irq_en & ~in_service_q;
    assign mie_w2   = status_mie_r | mie_d_q;
    assign ack_take = (state_q == IRQ_ST_REQ) & irq_i_ack;
    assign req_cond = ~dbg_mode & mie_w2 & sel_valid & (state_q != IRQ_ST_ISR);

    excp_irq_prio_enc #(
        .NUM_IRQ(NUM_IRQ)
    ) u_prio_enc (
        .eligible(eligible),
        .valid   (sel_valid),
        .index   (sel_index),
        .grant   (sel_grant)
    );

`ifdef EXCP_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= irq_in;
    end

    // Edge set wins over the ack clear of the presented channel.
    always_comb begin
        pend_d = (~irq_edge & irq_in)
               | (irq_edge & irq_in & ~prev_q)
               | (irq_edge & pend_q & ~({NUM_IRQ{ack_take}} & frozen_q));
    end
`else
    logic unused_edge;
    assign unused_edge = ^irq_edge;

    always_comb begin
        pend_d = irq_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IRQ_ST_IDLE;
            pend_q       <= '0;
            frozen_q     <= '0;
            in_service_q <= '0;
            req_q        <= 1'b0;
            cause_q      <= '0;
            mie_d_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            frozen_q     <= frozen_d;
            in_service_q <= in_service_d;
            req_q        <= req_d;
            cause_q      <= cause_d;
            mie_d_q      <= status_mie_r;
        end
    end

    always_comb begin
        state_d      = state_q;
        frozen_d     = frozen_q;
        in_service_d = in_service_q;
        req_d        = req_q;
        cause_d      = cause_q;
        case (state_q)
            IRQ_ST_IDLE: begin
                if (req_cond) begin
                    state_d  = IRQ_ST_REQ;
                    req_d    = 1'b1;
                    frozen_d = sel_grant;
                    cause_d  = {1'b1, (XLEN-1)'(CAUSE_BASE + 32'(sel_index))};
                end
            end
            IRQ_ST_REQ: begin
                if (irq_i_ack) begin
                    state_d      = IRQ_ST_ISR;
                    req_d        = 1'b0;
                    in_service_d = frozen_q;
                end else if (~|(eligible & frozen_q) | dbg_mode | ~mie_w2) begin
                    state_d  = IRQ_ST_IDLE;
                    req_d    = 1'b0;
                    cause_d  = '0;
                    frozen_d = '0;
                end
            end
            IRQ_ST_ISR: begin
                if (irq_i_cmpl) begin
                    state_d      = IRQ_ST_IDLE;
                    in_service_d = '0;
                    frozen_d     = '0;
                end
            end
            default: state_d = IRQ_ST_IDLE;
        endcase
    end

    assign irq_o_irq_req        = req_q;
    assign irq_o_irq_cause      = cause_q;
    assign irq_o_pend           = pend_q;
    assign irq_o_in_service     = in_service_q;
    assign irq_o_wfi_irq_req    = ~dbg_mode & |(pend_q & irq_en);
    assign irq_o_irq_req_active = irq_i_wfi_flag_r ? irq_o_wfi_irq_req : req_q;

endmodule
